// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared types and constants for the multiplexed hex display:
//                scan FSM state encoding, active-low 7-segment font table,
//                blank pattern and maximum digit count.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Largest supported digit count and the matching digit-index width
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W      = 3;

    // All segments off (active-low), decimal point included
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } scan_state_e;

    // Active-low glyphs, bit order {a,b,c,d,e,f,g}, indexed by nibble value
    localparam logic [6:0] SEG_FONT [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0001100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    // Full segment byte {a..g, dp} for a nibble and an active-high dp request
    function automatic logic [7:0] seg_encode(input logic [3:0] nibble, input logic dp);
        return {SEG_FONT[nibble], ~dp};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_scan_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_display_if
//  Description : Bundle of the display controller's data/control inputs and
//                its segment/anode outputs. The master side feeds the value
//                to show; the slave side is the scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hex_scan_display_if #(
    parameter int N_DIGITS = 8
);
    logic                  en;
    logic [4*N_DIGITS-1:0] num;
    logic [N_DIGITS-1:0]   dp;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  load;
    logic [7:0]            seg;
    logic [N_DIGITS-1:0]   anode;
    logic                  frame_done;

    modport master (
        output en, num, dp, digit_en, load,
        input  seg, anode, frame_done
    );

    modport slave (
        input  en, num, dp, digit_en, load,
        output seg, anode, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seg_hex_font.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_font
//  Description : Combinational hex nibble + decimal point to active-low
//                segment byte {a,b,c,d,e,f,g,dp}.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_font
    import seg_pkg::*;
(
    input  wire  [3:0] i_nibble,
    input  wire        i_dp,
    output logic [7:0] o_seg
);

    // Table lookup of the glyph with the dp bit appended
    always_comb begin
        o_seg = seg_encode(i_nibble, i_dp);
    end

endmodule
`default_nettype wire

// File: rtl/hex_scan_display.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scan_display
//  Description : Time-multiplexed hex display driver. Each digit is driven
//                for ON_CYCLES clocks followed by GAP_CYCLES all-off clocks.
//                New values are staged in a pending buffer and promoted to
//                the displayed (shadow) buffer only at frame boundaries.
//                Optional macro SEG_LZ_BLANK_EN blanks leading zero digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_scan_display
    import seg_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int ON_CYCLES  = 100000,
    parameter int GAP_CYCLES = 1000
) (
    input  wire               clk,
    input  wire               rst_n,
    hex_scan_display_if.slave bus
);

    localparam int CNT_MAX_A = (ON_CYCLES > 2) ? ON_CYCLES : 2;
    localparam int CNT_MAX   = (GAP_CYCLES > CNT_MAX_A) ? GAP_CYCLES : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] pend_num_q, pend_num_d;
    logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*N_DIGITS-1:0] shad_num_q, shad_num_d;
    logic [N_DIGITS-1:0]   shad_dp_q, shad_dp_d;
    logic [7:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   anode_q, anode_d;

    logic                  w_slot_end;
    logic                  w_frame_done;
    logic [3:0]            w_nibble;
    logic                  w_dp;
    logic                  w_lz_blank;
    logic [7:0]            w_font_seg;
`ifdef SEG_LZ_BLANK_EN
    logic                  w_hi_zero;
`endif

    // State, buffers and registered pin drivers; reset blanks the pins at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            pend_num_q <= '0;
            pend_dp_q  <= '0;
            shad_num_q <= '0;
            shad_dp_q  <= '0;
            seg_q      <= SEG_BLANK;
            anode_q    <= '1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            pend_num_q <= pend_num_d;
            pend_dp_q  <= pend_dp_d;
            shad_num_q <= shad_num_d;
            shad_dp_q  <= shad_dp_d;
            seg_q      <= seg_d;
            anode_q    <= anode_d;
        end
    end

    // Scan sequencing, buffer staging and frame wrap detection
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        pend_num_d   = pend_num_q;
        pend_dp_d    = pend_dp_q;
        shad_num_d   = shad_num_q;
        shad_dp_d    = shad_dp_q;
        w_slot_end   = 1'b0;
        w_frame_done = 1'b0;

        if (bus.load) begin
            pend_num_d = bus.num;
            pend_dp_d  = bus.dp;
        end

        if (!bus.en) begin
            // Disable overrides everything; the pending buffer survives
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ON;
                    idx_d      = '0;
                    cnt_d      = '0;
                    shad_num_d = pend_num_d;
                    shad_dp_d  = pend_dp_d;
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        if (HAS_GAP) begin
                            state_d = GAP;
                            cnt_d   = '0;
                        end else begin
                            w_slot_end = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        w_slot_end = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (w_slot_end) begin
                state_d = ON;
                cnt_d   = '0;
                if (idx_q == LAST_IDX) begin
                    // Frame wrap: promote pending (including a same-cycle load)
                    idx_d        = '0;
                    w_frame_done = 1'b1;
                    shad_num_d   = pend_num_d;
                    shad_dp_d    = pend_dp_d;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    // Select the nibble/dp of the digit that will be lit after this edge
    always_comb begin
        w_nibble   = 4'h0;
        w_dp       = 1'b0;
        w_lz_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) begin
                w_nibble = shad_num_d[4*i +: 4];
                w_dp     = shad_dp_d[i];
            end
        end
`ifdef SEG_LZ_BLANK_EN
        // A digit is blank when it and every higher digit are zero with no dp;
        // digit 0 is never visited here so it always shows
        w_hi_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            w_hi_zero = w_hi_zero & (shad_num_d[4*i +: 4] == 4'h0) & ~shad_dp_d[i];
            if (idx_d == IDX_W'(i)) begin
                w_lz_blank = w_hi_zero;
            end
        end
`endif
    end

    seg_hex_font u_font (
        .i_nibble (w_nibble),
        .i_dp     (w_dp),
        .o_seg    (w_font_seg)
    );

    // Next pin values; outputs are lit only in ON, anode gated by digit_en
    always_comb begin
        seg_d   = SEG_BLANK;
        anode_d = '1;
        if (state_d == ON) begin
            seg_d = w_lz_blank ? SEG_BLANK : w_font_seg;
            for (int i = 0; i < N_DIGITS; i++) begin
                if ((idx_d == IDX_W'(i)) && bus.digit_en[i]) begin
                    anode_d[i] = 1'b0;
                end
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.anode      = anode_q;
    assign bus.frame_done = w_frame_done;

endmodule
`default_nettype wire
